m_dmin_buf: RTL and testbench
=============================

M_DMIN_BUF -- requirements
Module: M_DMIN_BUF

Interface
REQ-001 SHALL have parameter DEPTH, default 2, store-buffer entry count; power of two, >=2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  32  M-stage effective address (load or store).
REQ-005 SHALL have port writeData  input  32  store source register value.
REQ-006 SHALL have port CU_DM_op  input  2  access size: 2'b00 word, 2'b01 byte, 2'b10 half; 2'b11 treated as word.
REQ-007 SHALL have ports is_store, is_load  input  1 each  M-stage instruction is a store or a load; never both high.
REQ-008 SHALL have port is_addrOv  input  1  address-calculation overflow flag from E stage.
REQ-009 SHALL have port req_flush  input  1  M-stage instruction is killed (exception/interrupt); blocks enqueue.
REQ-010 SHALL have ports bus_addr  output  32, bus_wdata  output  32, bus_byteen  output  4, bus_valid  output  1: head-entry write request.
REQ-011 SHALL have port bus_ready  input  1  memory/bridge accepts head entry this cycle.
REQ-012 SHALL have ports M_is_AdES  output  1  store address exception; M_stall  output  1  freeze F/D/E/M this cycle.

Function
REQ-013 SHALL flag align error: word with addr[1:0]!=0; half with addr[0]=1.
REQ-014 SHALL flag range error when addr outside 0x0000_0000-0x0000_2FFF, 0x0000_7F00-0x0000_7F0B, 0x0000_7F10-0x0000_7F1B, 0x0000_7F20-0x0000_7F23.
REQ-015 SHALL flag timer error for non-word access in 0x7F00-0x7F0B or 0x7F10-0x7F1B, and for any store to count registers 0x7F08-0x7F0B or 0x7F18-0x7F1B.
REQ-016 SHALL drive M_is_AdES = is_store & (align | range | timer | is_addrOv), combinationally.
REQ-017 SHALL form entry byte enable: word 4'b1111; half addr[1]?4'b1100:4'b0011; byte 4'b0001<<addr[1:0].
REQ-018 SHALL form entry data: word writeData; half {2{writeData[15:0]}}; byte {4{writeData[7:0]}}; entry address {addr[31:2],2'b00}.
REQ-019 SHALL enqueue at the clock edge iff is_store & !M_is_AdES & !req_flush & !full, full evaluated from registered state.
REQ-020 SHALL present head entry on bus_* with bus_valid = !empty; bus_addr/bus_wdata/bus_byteen stable while bus_valid & !bus_ready.
REQ-021 SHALL dequeue head at the clock edge iff bus_valid & bus_ready; FIFO order preserved.
REQ-022 SHALL allow enqueue and dequeue in the same cycle when not full; occupancy unchanged.
REQ-023 SHALL not enqueue when full even if dequeue occurs same cycle; store retries next cycle.
REQ-024 SHALL use wrap-around read/write pointers modulo DEPTH and an occupancy counter of width log2(DEPTH)+1.
REQ-025 SHALL drive M_stall = (is_store & full & !M_is_AdES & !req_flush) | (is_load & hit), hit = any valid entry with entry address[31:2] == addr[31:2].
REQ-026 SHALL evaluate hit against registered entries only; an entry dequeuing this cycle still counts as hit.
REQ-027 SHALL never drop committed entries on req_flush; flush affects only the current M-stage store.
REQ-028 SHALL give M_is_AdES priority: faulting store neither enqueues nor stalls.

Reset
REQ-029 SHALL, while reset=0, clear pointers and occupancy, making bus_valid=0, M_stall=0 (unless is_load hit, impossible when empty), bus_addr/bus_wdata/bus_byteen=0.
REQ-030 SHALL abandon in-flight entries on reset mid-operation; bus_valid falls asynchronously.

Verification
REQ-031 sb addr=0x0000_1003, writeData=0x1234_56AB, bus_ready=1 -> next cycle bus_valid=1, bus_addr=0x0000_1000, bus_wdata=0xABAB_ABAB, bus_byteen=4'b1000.
REQ-032 sh addr=0x0000_0002 writeData=0xFFFF_BEEF -> bus_wdata=0xBEEF_BEEF, bus_byteen=4'b1100; sh addr=0x0000_0001 -> M_is_AdES=1, no enqueue.
REQ-033 sw to 0x7F08, sb to 0x7F00, sw to 0x3000 -> M_is_AdES=1 each, M_stall=0, bus_valid stays 0.
REQ-034 bus_ready=0, three back-to-back sw (DEPTH=2) -> third cycle M_stall=1; raise bus_ready -> one dequeue, third store enqueues the following cycle, order 1,2,3 on bus.
REQ-035 sw 0x0000_0010 pending (bus_ready=0), lw 0x0000_0012 -> M_stall=1 until dequeue edge; lw 0x0000_0020 -> M_stall=0.
REQ-036 two entries pending, reset pulled low mid-cycle -> bus_valid=0 immediately; after release, empty buffer, no stale writes.

Source files
------------

// File: rtl/m_dmin_buf.sv
// Data-memory store buffer for the M stage.
// Checks each store for address exceptions, queues legal stores in a small
// FIFO and presents the oldest entry as a write request on the bus.
// Loads that hit a pending store are stalled until that store has drained,
// so a load can never read memory that is older than a store ahead of it.
module m_dmin_buf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic [1:0]  CU_DM_op,
  input  logic        is_store,
  input  logic        is_load,
  input  logic        is_addrOv,
  input  logic        req_flush,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        M_is_AdES,
  output logic        M_stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    OP_WORD     = 2'b00,
    OP_BYTE     = 2'b01,
    OP_HALF     = 2'b10,
    OP_WORD_ALT = 2'b11
  } dm_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  // Address map windows (inclusive bounds)
  localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
  localparam logic [31:0] T0_FIRST = 32'h0000_7F00;
  localparam logic [31:0] T0_LAST  = 32'h0000_7F0B;
  localparam logic [31:0] T0_CNT   = 32'h0000_7F08;
  localparam logic [31:0] T1_FIRST = 32'h0000_7F10;
  localparam logic [31:0] T1_LAST  = 32'h0000_7F1B;
  localparam logic [31:0] T1_CNT   = 32'h0000_7F18;
  localparam logic [31:0] T2_FIRST = 32'h0000_7F20;
  localparam logic [31:0] T2_LAST  = 32'h0000_7F23;

  // FIFO state
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic   full, empty;
  logic   enq, deq;
  logic   is_word, is_half, is_byte;
  logic   align_err, range_err, timer_err;
  logic   in_dm, in_t0, in_t1, in_t2, in_cnt;
  logic   hit;
  entry_t new_entry;
  entry_t head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Decode the access size; the reserved encoding behaves as a word access.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_word = 1'b1;
    is_half = 1'b0;
    is_byte = 1'b0;
    case (dm_op_e'(CU_DM_op))
      OP_BYTE: begin
        is_word = 1'b0;
        is_byte = 1'b1;
      end
      OP_HALF: begin
        is_word = 1'b0;
        is_half = 1'b1;
      end
      default: ;
    endcase
  end

  // Classify the address against the memory map and the access size.
  always_comb begin
    in_dm  = (addr <= DM_LAST);
    in_t0  = (addr >= T0_FIRST) && (addr <= T0_LAST);
    in_t1  = (addr >= T1_FIRST) && (addr <= T1_LAST);
    in_t2  = (addr >= T2_FIRST) && (addr <= T2_LAST);
    in_cnt = ((addr >= T0_CNT) && (addr <= T0_LAST)) ||
             ((addr >= T1_CNT) && (addr <= T1_LAST));

    align_err = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    range_err = !(in_dm || in_t0 || in_t1 || in_t2);
    // Timer registers take word accesses only, and their counters are read-only.
    timer_err = (!is_word && (in_t0 || in_t1)) || (is_store && in_cnt);
  end

  assign M_is_AdES = is_store && (align_err || range_err || timer_err || is_addrOv);

  // Build the word-aligned entry with lanes replicated and matching byte enables.
  always_comb begin
    new_entry.addr = {addr[31:2], 2'b00};
    new_entry.data = writeData;
    new_entry.be   = 4'b1111;
    if (is_half) begin
      new_entry.data = {2{writeData[15:0]}};
      new_entry.be   = addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_byte) begin
      new_entry.data = {4{writeData[7:0]}};
      new_entry.be   = 4'b0001 << addr[1:0];
    end
  end

  // Full is taken from registered occupancy, so a same-cycle dequeue does not
  // open a slot for the store; it retries next cycle under M_stall.
  assign enq = is_store && !M_is_AdES && !req_flush && !full;
  assign deq = bus_valid && bus_ready;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset empties the buffer and drops in-flight stores.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage written at the tail slot on enqueue.
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed once the pointers mark it valid, and the bus outputs are forced
  // to zero while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Load hazard check against registered entries only; an entry leaving this
  // cycle still counts, so the load waits until the write has really gone.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off = AW'(i) - rd_ptr_q;
      if (({1'b0, off} < cnt_q) && (mem_q[i].addr[31:2] == addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign M_stall = (is_store && full && !M_is_AdES && !req_flush) || (is_load && hit);

  // Head of the queue drives the bus; zero while nothing is pending.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    bus_valid  = !empty;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    if (!empty) begin
      bus_addr   = head.addr;
      bus_wdata  = head.data;
      bus_byteen = head.be;
    end
  end

endmodule

// File: tb/tb_m_dmin_buf.sv
// Directed test of the M-stage store buffer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_m_dmin_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [1:0]  CU_DM_op;
  logic        is_store, is_load, is_addrOv, req_flush;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_valid, bus_ready;
  logic        M_is_AdES, M_stall;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] W = 2'b00, B = 2'b01, H = 2'b10;

  always #5 clk = ~clk;

  m_dmin_buf #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writeData (writeData),
    .CU_DM_op  (CU_DM_op),
    .is_store  (is_store),
    .is_load   (is_load),
    .is_addrOv (is_addrOv),
    .req_flush (req_flush),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_byteen(bus_byteen),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .M_is_AdES (M_is_AdES),
    .M_stall   (M_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ld, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    is_store  = st;
    is_load   = ld;
    CU_DM_op  = op;
    addr      = a;
    writeData = wd;
    bus_ready = rdy;
    is_addrOv = 1'b0;
    req_flush = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, W, 32'h0, 32'h0, rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    check({tag, "_valid"}, 32'(bus_valid), 32'd1);
    check({tag, "_addr"},  bus_addr, a);
    check({tag, "_wdata"}, bus_wdata, d);
    check({tag, "_byteen"}, 32'(bus_byteen), 32'(be));
  endtask

  initial begin
    reset = 1'b0;
    idle(1'b0);
    tick();
    tick();
    sample();
    check("rst_valid",  32'(bus_valid), 32'd0);
    check("rst_addr",   bus_addr, 32'h0);
    check("rst_wdata",  bus_wdata, 32'h0);
    check("rst_byteen", 32'(bus_byteen), 32'h0);
    check("rst_stall",  32'(M_stall), 32'd0);
    reset = 1'b1;

    // sb 0x1003: lane 3, data replicated
    tick();
    drive(1'b1, 1'b0, B, 32'h0000_1003, 32'h1234_56AB, 1'b1);
    sample();
    check("sb_ades",  32'(M_is_AdES), 32'd0);
    check("sb_stall", 32'(M_stall), 32'd0);
    tick();
    idle(1'b1);
    sample();
    check_head("sb", 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    tick();
    sample();
    check("sb_drained", 32'(bus_valid), 32'd0);

    // sh 0x2 then misaligned sh 0x1 (rejected)
    tick();
    drive(1'b1, 1'b0, H, 32'h0000_0002, 32'hFFFF_BEEF, 1'b0);
    sample();
    check("sh_ades", 32'(M_is_AdES), 32'd0);
    tick();
    drive(1'b1, 1'b0, H, 32'h0000_0001, 32'hFFFF_BEEF, 1'b0);
    sample();
    check("sh_mis_ades",  32'(M_is_AdES), 32'd1);
    check("sh_mis_stall", 32'(M_stall), 32'd0);
    check_head("sh", 32'h0000_0000, 32'hBEEF_BEEF, 4'b1100);
    tick();
    idle(1'b1);
    sample();
    check_head("sh_hold", 32'h0000_0000, 32'hBEEF_BEEF, 4'b1100);
    tick();
    idle(1'b0);
    sample();
    check("sh_mis_noenq", 32'(bus_valid), 32'd0);

    // Flushed store must not enqueue
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0100, 32'h1111_1111, 1'b0);
    req_flush = 1'b1;
    sample();
    check("flush_ades",  32'(M_is_AdES), 32'd0);
    check("flush_stall", 32'(M_stall), 32'd0);
    tick();
    idle(1'b0);
    sample();
    check("flush_noenq", 32'(bus_valid), 32'd0);

    // Address exceptions
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_7F08, 32'h1, 1'b0);
    sample();
    check("sw_cnt_ades",  32'(M_is_AdES), 32'd1);
    check("sw_cnt_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, B, 32'h0000_7F00, 32'h2, 1'b0);
    sample();
    check("sb_tmr_ades",  32'(M_is_AdES), 32'd1);
    check("sb_tmr_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_3000, 32'h3, 1'b0);
    sample();
    check("sw_rng_ades",  32'(M_is_AdES), 32'd1);
    check("sw_rng_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0000, 32'h4, 1'b0);
    is_addrOv = 1'b1;
    sample();
    check("sw_ov_ades", 32'(M_is_AdES), 32'd1);
    tick();
    drive(1'b0, 1'b1, W, 32'h0000_7F08, 32'h0, 1'b0);
    sample();
    check("lw_cnt_ades", 32'(M_is_AdES), 32'd0);
    tick();
    idle(1'b0);
    sample();
    check("exc_noenq", 32'(bus_valid), 32'd0);

    // Full buffer: three back-to-back stores with bus stalled
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0100, 32'h0000_0001, 1'b0);
    sample();
    check("full_s1_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0104, 32'h0000_0002, 1'b0);
    sample();
    check("full_s2_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0108, 32'h0000_0003, 1'b0);
    sample();
    check("full_s3_stall", 32'(M_stall), 32'd1);
    check_head("full_h1", 32'h0000_0100, 32'h0000_0001, 4'b1111);
    tick();
    bus_ready = 1'b1;
    sample();
    check("full_deq_stall", 32'(M_stall), 32'd1);
    tick();
    bus_ready = 1'b0;
    sample();
    check("full_retry_stall", 32'(M_stall), 32'd0);
    check_head("full_h2", 32'h0000_0104, 32'h0000_0002, 4'b1111);
    tick();
    idle(1'b1);
    sample();
    check_head("full_h2b", 32'h0000_0104, 32'h0000_0002, 4'b1111);
    tick();
    sample();
    check_head("full_h3", 32'h0000_0108, 32'h0000_0003, 4'b1111);
    tick();
    sample();
    check("full_drained", 32'(bus_valid), 32'd0);

    // Load hazard against a pending store
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0010, 32'h0000_0055, 1'b0);
    tick();
    drive(1'b0, 1'b1, W, 32'h0000_0012, 32'h0, 1'b0);
    sample();
    check("lw_hit_stall", 32'(M_stall), 32'd1);
    tick();
    sample();
    check("lw_hit_stall2", 32'(M_stall), 32'd1);
    addr = 32'h0000_0020;
    #1;
    check("lw_miss_stall", 32'(M_stall), 32'd0);
    tick();
    drive(1'b0, 1'b1, W, 32'h0000_0012, 32'h0, 1'b1);
    sample();
    check("lw_deq_stall", 32'(M_stall), 32'd1);
    tick();
    sample();
    check("lw_after_stall", 32'(M_stall), 32'd0);
    check("lw_after_valid", 32'(bus_valid), 32'd0);

    // Simultaneous enqueue and dequeue
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0200, 32'h0000_00A0, 1'b1);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0204, 32'h0000_00A1, 1'b1);
    sample();
    check_head("sim_h1", 32'h0000_0200, 32'h0000_00A0, 4'b1111);
    tick();
    idle(1'b1);
    sample();
    check_head("sim_h2", 32'h0000_0204, 32'h0000_00A1, 4'b1111);
    tick();
    sample();
    check("sim_drained", 32'(bus_valid), 32'd0);

    // Reset with two entries pending
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0300, 32'h0000_000A, 1'b0);
    tick();
    drive(1'b1, 1'b0, W, 32'h0000_0304, 32'h0000_000B, 1'b0);
    tick();
    drive(1'b0, 1'b1, W, 32'h0000_0300, 32'h0, 1'b0);
    #1;
    check("pre_rst_valid", 32'(bus_valid), 32'd1);
    check("pre_rst_stall", 32'(M_stall), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus_valid), 32'd0);
    check("rst_mid_addr",  bus_addr, 32'h0);
    check("rst_mid_stall", 32'(M_stall), 32'd0);
    tick();
    sample();
    reset = 1'b1;
    idle(1'b1);
    tick();
    sample();
    check("post_rst_valid", 32'(bus_valid), 32'd0);
    tick();
    sample();
    check("post_rst_valid2", 32'(bus_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
